// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO controller, its storage array and read-side clients.
// Also holds the output-queue state encoding and the frame-position width helper.
package fifo_pkg;

  localparam int STACK_WIDTH     = 8;
  localparam int STACK_HEIGHT    = 8;
  localparam int STACK_PTR_WIDTH = 3;
  localparam int FRAME_CNT_W     = 16;
  localparam int FRAME_LEN_DEF   = 4;

  // Encoding doubles as the queue occupancy count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_PART  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic int wpos_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_read_streamer_if.sv
// Valid/ready output stream with frame delimiting, as seen by the downstream consumer.
interface fifo_read_streamer_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH
) ();

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered output queue with push/pop/flush; occupancy is the FSM state.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [1:0]       buf_cnt,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);

  buf_state_t       state_reg;
  buf_state_t       state_next;
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic             pop_en;
  logic             push_en;
  logic [WIDTH-1:0] entry_data [2];

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign pop_en  = pop & (state_reg != BUF_EMPTY) & ~flush;
  assign push_en = push & ~flush & ((state_reg != BUF_FULL) | pop_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BUF_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state_reg)
        BUF_EMPTY: if (push_en) state_next = BUF_PART;
        BUF_PART: begin
          if (push_en && !pop_en) begin
            state_next = BUF_FULL;
          end else if (pop_en && !push_en) begin
            state_next = BUF_EMPTY;
          end
        end
        BUF_FULL:  if (pop_en && !push_en) state_next = BUF_PART;
        default:   state_next = BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    valid     = (state_reg != BUF_EMPTY);
    buf_cnt   = 2'(state_reg);
    head_data = entry_data[rd_ptr_reg];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (pop_en) rd_ptr_reg <= ~rd_ptr_reg;
      if (push_en) wr_ptr_reg <= ~wr_ptr_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push_en && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign entry_data[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-side FIFO consumer: issues read pulses, captures the synchronous read word and
// presents it as a framed valid/ready stream with a delivered-frame counter.
module fifo_read_streamer #(
  parameter int STACK_WIDTH = fifo_pkg::STACK_WIDTH,
  parameter int FRAME_LEN   = fifo_pkg::FRAME_LEN_DEF,
  parameter int FCNT_W      = fifo_pkg::FRAME_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   stack_empty,
  input  logic [STACK_WIDTH-1:0] rd_data,
  output logic                   read_from_stack,
  fifo_read_streamer_if.master   m_if,
  output logic [FCNT_W-1:0]      frame_count
);

  localparam int                WPOS_W   = fifo_pkg::wpos_width(FRAME_LEN);
  localparam logic [WPOS_W-1:0] LAST_POS = WPOS_W'(FRAME_LEN - 1);

  logic                   inflight_reg;
  logic [WPOS_W-1:0]      wpos_reg;
  logic [WPOS_W-1:0]      wpos_next;
  logic [FCNT_W-1:0]      frame_count_reg;
  logic [FCNT_W-1:0]      frame_count_next;
  logic [1:0]             buf_cnt;
  logic                   buf_valid;
  logic [STACK_WIDTH-1:0] head_data;
  logic                   pop;
  logic                   pop_counted;
  logic                   push;
  logic                   last_beat;
  logic [2:0]             occupancy;

  // Occupancy counts words already queued plus the one in flight, minus the one leaving now.
  assign pop         = buf_valid & m_if.m_ready;
  assign occupancy   = {1'b0, buf_cnt} + {2'b00, inflight_reg} - {2'b00, pop};
  assign read_from_stack = ~rst & en & ~flush & ~stack_empty & (occupancy < 3'd2);
  assign push        = inflight_reg & ~flush;
  assign pop_counted = pop & ~flush;
  assign last_beat   = buf_valid & (wpos_reg == LAST_POS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= read_from_stack;
    end
  end

  stream_skid_buf #(
    .WIDTH(STACK_WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_data(rd_data),
    .buf_cnt  (buf_cnt),
    .valid    (buf_valid),
    .head_data(head_data)
  );

  always_comb begin
    wpos_next        = wpos_reg;
    frame_count_next = frame_count_reg;
    if (flush) begin
      wpos_next = '0;
    end else if (pop_counted) begin
      if (last_beat) begin
        wpos_next        = '0;
        frame_count_next = frame_count_reg + FCNT_W'(1);
      end else begin
        wpos_next = wpos_reg + WPOS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wpos_reg        <= '0;
      frame_count_reg <= '0;
    end else begin
      wpos_reg        <= wpos_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign m_if.m_valid = buf_valid;
  assign m_if.m_data  = head_data;
  assign m_if.m_last  = last_beat;
  assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed + random bench for fifo_read_streamer with a FIFO storage model and a
// scoreboard monitor that checks every accepted beat against the expected-word queue.
module tb_fifo_read_streamer;

  localparam int W     = 8;
  localparam int FL    = 4;
  localparam int FW    = 16;
  localparam int SRC_N = 8192;
  localparam int EXP_N = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic          stack_empty;
  logic [W-1:0]  rd_data = '0;
  logic          read_from_stack;
  logic [FW-1:0] frame_count;

  fifo_read_streamer_if #(.WIDTH(W)) stream ();

  fifo_read_streamer #(
    .STACK_WIDTH(W),
    .FRAME_LEN  (FL),
    .FCNT_W     (FW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .flush          (flush),
    .stack_empty    (stack_empty),
    .rd_data        (rd_data),
    .read_from_stack(read_from_stack),
    .m_if           (stream.master),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  // FIFO storage model: words written by the stimulus, read out one per read pulse.
  logic [W-1:0] src [SRC_N];
  int wr_count = 0;
  int rd_count = 0;
  int empty_viol = 0;

  assign stack_empty = (rd_count >= wr_count);

  always @(posedge clk) begin
    if (read_from_stack) begin
      if (stack_empty || rst) empty_viol <= empty_viol + 1;
      rd_data  <= src[rd_count % SRC_N];
      rd_count <= rd_count + 1;
    end
  end

  logic [W-1:0] exp_data [EXP_N];
  int exp_wr = 0;
  int exp_rd = 0;
  int total = 0;
  int bad = 0;
  int delivered = 0;
  int mon_pos = 0;
  int mon_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, want);
    end
  endtask

  // Scoreboard monitor: one accepted beat per negedge where valid & ready and no flush.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pos    = 0;
        mon_frames = 0;
      end else if (flush) begin
        mon_pos = 0;
      end else if (stream.m_valid && stream.m_ready) begin
        $display("beat %0d data=0x%02h last=%0b", delivered, stream.m_data, stream.m_last);
        if (exp_rd >= exp_wr) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got=0x%0h want=none", stream.m_data);
        end else begin
          check("beat_data", 32'(stream.m_data), 32'(exp_data[exp_rd % EXP_N]));
          exp_rd++;
        end
        check("beat_last", 32'(stream.m_last), 32'(mon_pos == FL - 1));
        if (mon_pos == FL - 1) begin
          mon_pos = 0;
          mon_frames++;
        end else begin
          mon_pos++;
        end
        delivered++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [W-1:0] v, input bit expect_it);
    src[wr_count % SRC_N] = v;
    wr_count++;
    if (expect_it) begin
      exp_data[exp_wr % EXP_N] = v;
      exp_wr++;
    end
  endtask

  task automatic wait_delivered(input string name, input int target, input int budget);
    int n = 0;
    while (delivered < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(delivered), 32'(target));
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int base;
    int beats;
    int first_cyc;
    int last_cyc;
    int reads;
    int nwr;

    rst = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    stream.m_ready = 1'b0;

    // Reset state, with a word already waiting in the FIFO.
    wr_word(8'hA5, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(stream.m_valid), 0);
    check("rst_last", 32'(stream.m_last), 0);
    check("rst_data", 32'(stream.m_data), 0);
    check("rst_read", 32'(read_from_stack), 0);
    check("rst_fcnt", 32'(frame_count), 0);

    // First-word latency: read in cycle 0, nothing valid in 1, data in 2.
    tick();
    rst = 1'b0;
    en = 1'b1;
    stream.m_ready = 1'b1;
    @(negedge clk);
    check("lat_c0_read", 32'(read_from_stack), 1);
    check("lat_c0_valid", 32'(stream.m_valid), 0);
    tick();
    @(negedge clk);
    check("lat_c1_valid", 32'(stream.m_valid), 0);
    tick();
    @(negedge clk);
    check("lat_c2_valid", 32'(stream.m_valid), 1);
    check("lat_c2_data", 32'(stream.m_data), 32'h0000_00A5);
    repeat (3) tick();
    flush_pulse();

    // Streaming 0x01..0x08 with ready high: back-to-back beats, two frames.
    for (int i = 1; i <= 8; i++) wr_word(W'(i), 1'b1);
    beats = 0;
    first_cyc = -1;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
      @(negedge clk);
      if (stream.m_valid && stream.m_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
    end
    tick();
    check("stream_beats", 32'(beats), 8);
    check("stream_span", 32'(last_cyc - first_cyc), 7);
    @(negedge clk);
    check("stream_fcnt", 32'(frame_count), 2);
    tick();

    // Back-pressure: only two reads issue while ready is low.
    stream.m_ready = 1'b0;
    base = delivered;
    for (int i = 1; i <= 6; i++) wr_word(W'(i), 1'b1);
    reads = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (read_from_stack) reads++;
    end
    check("bp_reads", 32'(reads), 2);
    check("bp_read_idle", 32'(read_from_stack), 0);
    check("bp_head_valid", 32'(stream.m_valid), 1);
    check("bp_head_data", 32'(stream.m_data), 32'h0000_0001);
    tick();
    stream.m_ready = 1'b1;
    wait_delivered("bp_drain", base + 6, 40);
    tick();
    flush_pulse();
    @(negedge clk);
    check("bp_fcnt_after_flush", 32'(frame_count), 3);

    // Flush with one word queued and one in flight: 0x12/0x13 are discarded.
    tick();
    base = delivered;
    wr_word(8'h11, 1'b1);
    wr_word(8'h12, 1'b0);
    wr_word(8'h13, 1'b0);
    wr_word(8'h14, 1'b1);
    wr_word(8'h15, 1'b1);
    wr_word(8'h16, 1'b1);
    wait_delivered("fl_first", base + 1, 20);
    flush = 1'b1;
    @(negedge clk);
    check("fl_read_in_flush", 32'(read_from_stack), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fl_valid_after", 32'(stream.m_valid), 0);
    wait_delivered("fl_rest", base + 4, 40);
    tick();
    flush_pulse();
    @(negedge clk);
    check("fl_fcnt", 32'(frame_count), 3);

    // Reset mid-stream with the queue full.
    tick();
    stream.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr_word(W'(8'h21 + i), 1'b0);
    repeat (6) tick();
    @(negedge clk);
    check("rm_pre_valid", 32'(stream.m_valid), 1);
    tick();
    rst = 1'b1;
    wr_count = rd_count;
    @(negedge clk);
    check("rm_valid", 32'(stream.m_valid), 0);
    check("rm_last", 32'(stream.m_last), 0);
    check("rm_data", 32'(stream.m_data), 0);
    check("rm_read", 32'(read_from_stack), 0);
    check("rm_fcnt", 32'(frame_count), 0);
    tick();
    rst = 1'b0;
    stream.m_ready = 1'b1;
    @(negedge clk);
    check("rm_idle_read", 32'(read_from_stack), 0);

    // Random en/ready/writes against the scoreboard.
    base = delivered;
    nwr = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      en = ($urandom_range(0, 3) != 0);
      stream.m_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) begin
        wr_word(W'($urandom), 1'b1);
        nwr++;
      end
    end
    tick();
    en = 1'b1;
    stream.m_ready = 1'b1;
    wait_delivered("rand_drain", base + nwr, 5000);
    tick();
    @(negedge clk);
    check("rand_fcnt", 32'(frame_count), 32'(mon_frames % (1 << FW)));
    check("exp_consumed", 32'(exp_rd), 32'(exp_wr));
    check("empty_guard", 32'(empty_viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
